// File: rtl/ram_shifter_pkg.sv
// Purpose : shared constants and elaboration-time helpers for the RAM-backed
//           bit-serial frame shifter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package ram_shifter_pkg;

    // Frame width used when the top is instantiated without overrides.
    localparam int DEFAULT_IO_WIDTH = 16;

    // Ceiling log2 for parameter arithmetic; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Number of bits held by the frame store: one bit per {bank, addr}.
    function automatic int init_width(input int num_banks, input int addr_width);
        return num_banks * (1 << addr_width);
    endfunction

endpackage

// File: rtl/ram_shifter_dbuf_dpram_dist_1b.sv
// Purpose : 1-bit dual-port distributed RAM, synchronous write on one port and
//           asynchronous read on the other (RAM32X1D/RAM64X1D/RAM128X1D shape).
// Latency : write lands at the clock edge; dpo follows ra combinationally.
// Backpressure: none; a write is accepted every cycle we is high.
//
// Ports:
//   clk  clock for the write port
//   we   write enable
//   wa   write address
//   d    write data
//   ra   read address
//   dpo  read data (combinational from ra)
module dpram_dist_1b #(
    parameter int                            DEPTH_LOG2 = 6,
    parameter logic [(1 << DEPTH_LOG2)-1:0]  INIT       = '0
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wa,
    input  logic                  d,
    input  logic [DEPTH_LOG2-1:0] ra,
    output logic                  dpo
);

    // Configuration-time contents only; nothing in the design clears this
    // array, so a reset leaves previously written frames in place.
    logic [(1 << DEPTH_LOG2)-1:0] mem = INIT;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= d;
        end
    end

    assign dpo = mem[ra];

endmodule

// File: rtl/ram_shifter_dbuf.sv
// Purpose : multi-buffered bit-serial shifter; one bit of `in` is written to the
//           write bank and the same position is read from the read bank per cycle.
// Latency : out[k] updates one cycle after addr==k; a frame written in bank B
//           appears on out during the first full frame after B becomes rd_bank.
// Backpressure: none; runs every cycle, bank rotation is requested via
//           swap_req/auto_swap and acknowledged with a one-cycle swap_ack.
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst        synchronous active-high reset
//   in         parallel frame data, sampled one bit per cycle at position addr
//   out        registered parallel data assembled from the read bank
//   swap_req   request bank rotation at the next frame boundary (level or pulse)
//   auto_swap  rotate at every frame boundary while high
//   swap_ack   one-cycle pulse in the first cycle after a rotation
//   addr       current bit position (0 .. IO_WIDTH-1)
//   wr_bank    bank being written
//   rd_bank    bank being read
module ram_shifter_dbuf
    import ram_shifter_pkg::*;
#(
    parameter int   IO_WIDTH   = DEFAULT_IO_WIDTH,
    parameter int   ADDR_WIDTH = 5,
    parameter int   NUM_BANKS  = 2,
    parameter logic [init_width(NUM_BANKS, ADDR_WIDTH)-1:0] INIT = '0,
    localparam int  BANK_WIDTH = clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IO_WIDTH-1:0]   in,
    output logic [IO_WIDTH-1:0]   out,
    input  logic                  swap_req,
    input  logic                  auto_swap,
    output logic                  swap_ack,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [BANK_WIDTH-1:0] wr_bank,
    output logic [BANK_WIDTH-1:0] rd_bank
);

    localparam int                  DEPTH_LOG2 = ADDR_WIDTH + BANK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IO_WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } swap_state_t;

    swap_state_t state;
    swap_state_t state_next;

    logic boundary;
    logic rotate;
    logic wr_bit;
    logic rd_bit;

    assign boundary = (addr == LAST_ADDR);

    // ------------------------------------------------------------------
    // Swap FSM: PENDING remembers a request seen earlier in the frame.
    // A request in the boundary cycle itself rotates directly and is
    // consumed there, so it never leaves the FSM armed for the next frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rotate     = 1'b0;
        if (boundary && ((state == S_PENDING) || swap_req || auto_swap)) begin
            rotate     = 1'b1;
            state_next = S_IDLE;
        end else if (swap_req) begin
            state_next = S_PENDING;
        end
    end

    // ------------------------------------------------------------------
    // Bit select of the incoming frame. A compare loop keeps the index
    // width independent of IO_WIDTH vs 2**ADDR_WIDTH.
    // ------------------------------------------------------------------
    always_comb begin
        wr_bit = 1'b0;
        for (int i = 0; i < IO_WIDTH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                wr_bit = in[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame store. rd_bank never equals wr_bank, so the async read port
    // never observes the location being written in the same cycle.
    // Writes are suppressed in reset cycles to leave the RAM untouched.
    // ------------------------------------------------------------------
    dpram_dist_1b #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT       (INIT)
    ) u_ram (
        .clk (clk),
        .we  (~rst),
        .wa  ({wr_bank, addr}),
        .d   (wr_bit),
        .ra  ({rd_bank, addr}),
        .dpo (rd_bit)
    );

    // ------------------------------------------------------------------
    // Counter, bank pointers, ack pulse and output shift register.
    // NUM_BANKS is a power of two, so wr_bank wraps by plain overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            wr_bank  <= '0;
            rd_bank  <= BANK_WIDTH'(NUM_BANKS - 1);
            swap_ack <= 1'b0;
            out      <= '0;
        end else begin
            addr     <= boundary ? '0 : addr + ADDR_WIDTH'(1);
            swap_ack <= rotate;
            if (rotate) begin
                rd_bank <= wr_bank;
                wr_bank <= wr_bank + BANK_WIDTH'(1);
            end
            for (int i = 0; i < IO_WIDTH; i++) begin
                if (addr == ADDR_WIDTH'(i)) begin
                    out[i] <= rd_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_shifter_dbuf.sv
// Purpose : self-checking bench for ram_shifter_dbuf across three parameter sets
//           (16b/2 banks, 16b/4 banks auto-swap, 12b/2 banks).
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ram_shifter_dbuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- DUT A: defaults (16 bits, 2 banks) ----------------
    logic        a_rst = 1'b1;
    logic [15:0] a_in = '0;
    logic [15:0] a_out;
    logic        a_swap_req = 1'b0;
    logic        a_auto = 1'b0;
    logic        a_ack;
    logic [4:0]  a_addr;
    logic        a_wr;
    logic        a_rd;

    ram_shifter_dbuf u_dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .in        (a_in),
        .out       (a_out),
        .swap_req  (a_swap_req),
        .auto_swap (a_auto),
        .swap_ack  (a_ack),
        .addr      (a_addr),
        .wr_bank   (a_wr),
        .rd_bank   (a_rd)
    );

    // ---------------- DUT B: 4 banks ----------------
    logic        b_rst = 1'b1;
    logic [15:0] b_in = '0;
    logic [15:0] b_out;
    logic        b_swap_req = 1'b0;
    logic        b_auto = 1'b0;
    logic        b_ack;
    logic [4:0]  b_addr;
    logic [1:0]  b_wr;
    logic [1:0]  b_rd;

    ram_shifter_dbuf #(
        .IO_WIDTH   (16),
        .ADDR_WIDTH (5),
        .NUM_BANKS  (4)
    ) u_dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .in        (b_in),
        .out       (b_out),
        .swap_req  (b_swap_req),
        .auto_swap (b_auto),
        .swap_ack  (b_ack),
        .addr      (b_addr),
        .wr_bank   (b_wr),
        .rd_bank   (b_rd)
    );

    // ---------------- DUT C: 12 bits, 4-bit counter ----------------
    logic        c_rst = 1'b1;
    logic [11:0] c_in = '0;
    logic [11:0] c_out;
    logic        c_swap_req = 1'b0;
    logic        c_auto = 1'b0;
    logic        c_ack;
    logic [3:0]  c_addr;
    logic        c_wr;
    logic        c_rd;

    ram_shifter_dbuf #(
        .IO_WIDTH   (12),
        .ADDR_WIDTH (4),
        .NUM_BANKS  (2)
    ) u_dut_c (
        .clk       (clk),
        .rst       (c_rst),
        .in        (c_in),
        .out       (c_out),
        .swap_req  (c_swap_req),
        .auto_swap (c_auto),
        .swap_ack  (c_ack),
        .addr      (c_addr),
        .wr_bank   (c_wr),
        .rd_bank   (c_rd)
    );

    // ---------------- frame-level vector table for DUT A ----------------
    typedef struct {
        logic [15:0] din;
        logic [15:0] swap_mask;   // bit k set: swap_req high in the cycle addr==k
        logic        auto;
        logic [15:0] exp_out;     // out at the start of the following frame
        logic        exp_ack;
        logic        exp_wr;
        logic        exp_rd;
    } frame_vec_t;

    frame_vec_t tbl [10];

    // ---------------- reference model state for DUT A ----------------
    logic [15:0] m_mem [2];
    logic [15:0] m_out;
    int          m_addr;
    int          m_wr;
    int          m_rd;
    logic        m_pend;
    logic        m_ack;
    logic        r_rst;
    logic        r_sr;
    logic        r_auto;
    logic [15:0] r_in;
    logic        rot;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_frame(input int r);
        chk($sformatf("a_frame%0d_out", r), 64'(a_out), 64'(tbl[r].exp_out));
        chk($sformatf("a_frame%0d_ack_wr_rd_addr", r), 64'({a_ack, a_wr, a_rd, a_addr}),
            64'({tbl[r].exp_ack, tbl[r].exp_wr, tbl[r].exp_rd, 5'd0}));
    endtask

    // Frame-granular model: a bank is a whole frame, rotation happens only
    // when the last bit position of a frame is processed.
    task automatic model_step();
        if (r_rst) begin
            m_addr = 0;
            m_wr   = 0;
            m_rd   = 1;
            m_out  = '0;
            m_ack  = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_out[m_addr]        = m_mem[m_rd][m_addr];
            m_mem[m_wr][m_addr]  = r_in[m_addr];
            rot    = (m_addr == 15) && (m_pend || r_sr || r_auto);
            m_ack  = rot;
            if (rot) begin
                m_rd   = m_wr;
                m_wr   = (m_wr + 1) % 2;
                m_pend = 1'b0;
            end else if (r_sr) begin
                m_pend = 1'b1;
            end
            m_addr = (m_addr + 1) % 16;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'hA5C3, 16'h0020, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b0, 16'hA5C3, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'hA5C3, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h1234, 16'h0208, 1'b0, 16'hA5C3, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'h5A5A, 16'h8000, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'hFFFF, 16'h0000, 1'b0, 16'h5A5A, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{16'h0F0F, 16'h0001, 1'b0, 16'h5A5A, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{16'hC0DE, 16'h8004, 1'b0, 16'h0F0F, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{16'h0000, 16'h0000, 1'b0, 16'hC0DE, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{16'hBEEF, 16'h0000, 1'b1, 16'hC0DE, 1'b1, 1'b0, 1'b1};

        // ---------- A: reset held for two edges ----------
        tick();
        tick();
        chk("a_reset", 64'({a_out, a_addr, a_wr, a_rd, a_ack}),
            64'({16'h0000, 5'd0, 1'b0, 1'b1, 1'b0}));
        a_rst = 1'b0;

        // ---------- A: counter and no-swap toggling (out stays INIT) ----------
        for (int i = 0; i < 32; i++) begin
            chk("a_count_idle", 64'({a_addr, a_out, a_ack, a_wr, a_rd}),
                64'({5'(i % 16), 16'h0000, 1'b0, 1'b0, 1'b1}));
            a_in = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            tick();
        end

        // ---------- A: table of frames ----------
        for (int r = 0; r < 10; r++) begin
            for (int a = 0; a < 16; a++) begin
                if (a == 0 && r > 0) begin
                    check_frame(r - 1);
                end else if (a != 0) begin
                    chk("a_ack_midframe", 64'({a_ack, a_addr}), 64'({1'b0, 5'(a)}));
                end
                a_in       = tbl[r].din;
                a_swap_req = tbl[r].swap_mask[a];
                a_auto     = tbl[r].auto;
                tick();
            end
        end
        check_frame(9);

        // ---------- A: randomized run against the model ----------
        m_mem[0] = 16'hC0DE;
        m_mem[1] = 16'hBEEF;
        m_out    = 16'hC0DE;
        m_addr   = 0;
        m_wr     = 0;
        m_rd     = 1;
        m_pend   = 1'b0;
        m_ack    = 1'b1;
        for (int i = 0; i < 800; i++) begin
            chk("a_model", 64'({a_out, a_addr, a_wr, a_rd, a_ack}),
                64'({m_out, 5'(m_addr), 1'(m_wr), 1'(m_rd), m_ack}));
            r_rst  = ($urandom_range(0, 59) == 0);
            r_sr   = ($urandom_range(0, 19) == 0);
            r_auto = ($urandom_range(0, 9) == 0);
            r_in   = 16'($urandom);
            a_rst      = r_rst;
            a_swap_req = r_sr;
            a_auto     = r_auto;
            a_in       = r_in;
            model_step();
            tick();
        end
        chk("a_model_final", 64'({a_out, a_addr, a_wr, a_rd, a_ack}),
            64'({m_out, 5'(m_addr), 1'(m_wr), 1'(m_rd), m_ack}));
        a_rst = 1'b1;

        // ---------- B: 4 banks, auto rotation every frame ----------
        b_auto = 1'b1;
        tick();
        chk("b_reset", 64'({b_wr, b_rd, b_ack, b_addr, b_out}),
            64'({2'd0, 2'd3, 1'b0, 5'd0, 16'h0000}));
        b_rst = 1'b0;
        for (int f = 0; f < 6; f++) begin
            for (int a = 0; a < 16; a++) begin
                if (a == 0 && f > 0) begin
                    chk($sformatf("b_frame%0d_banks_ack", f), 64'({b_wr, b_rd, b_ack, b_addr}),
                        64'({2'(f % 4), 2'((f + 3) % 4), 1'b1, 5'd0}));
                    chk($sformatf("b_frame%0d_out", f), 64'(b_out),
                        64'((f >= 2) ? 16'(16'h1111 * (f - 1)) : 16'h0000));
                end else if (a != 0) begin
                    chk("b_ack_midframe", 64'(b_ack), 64'(1'b0));
                end
                b_in = 16'(16'h1111 * (f + 1));
                tick();
            end
        end
        chk("b_frame6_banks_ack", 64'({b_wr, b_rd, b_ack, b_addr}),
            64'({2'd2, 2'd1, 1'b1, 5'd0}));
        chk("b_frame6_out", 64'(b_out), 64'(16'h5555));
        b_rst = 1'b1;

        // ---------- C: 12-bit frame, wrap at 11 ----------
        tick();
        chk("c_reset", 64'({c_out, c_addr, c_wr, c_rd, c_ack}),
            64'({12'h000, 4'd0, 1'b0, 1'b1, 1'b0}));
        c_rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("c_wrap_addr", 64'({c_addr, c_ack}), 64'({4'(i), 1'b0}));
            c_in       = 12'hABC;
            c_swap_req = (i == 2);
            tick();
        end
        chk("c_rotate_at_11", 64'({c_addr, c_ack, c_wr, c_rd, c_out}),
            64'({4'd0, 1'b1, 1'b1, 1'b0, 12'h000}));

        // ---------- C: reset mid-frame with a request pending ----------
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                chk("c_ack_midframe", 64'(c_ack), 64'(1'b0));
            end
            c_in       = 12'h123;
            c_swap_req = (i == 2);
            tick();
        end
        c_swap_req = 1'b0;
        chk("c_addr_before_reset", 64'(c_addr), 64'(4'd7));
        c_rst = 1'b1;
        tick();
        chk("c_after_reset", 64'({c_addr, c_wr, c_rd, c_ack, c_out}),
            64'({4'd0, 1'b0, 1'b1, 1'b0, 12'h000}));
        c_rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("c_no_stale_swap", 64'({c_ack, c_wr, c_rd, c_addr}),
                64'({1'b0, 1'b0, 1'b1, 4'(i)}));
            c_in = 12'hFFF;
            tick();
        end
        chk("c_frame_after_reset", 64'({c_ack, c_wr, c_rd, c_addr}),
            64'({1'b0, 1'b0, 1'b1, 4'd0}));
        // Bank 1 keeps the seven bits written before reset; the rest are INIT.
        chk("c_partial_frame_kept", 64'(c_out), 64'(12'h023));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_shifter_dbuf.md
Name: ram_shifter_dbuf

Overview:
Parametrised double/multi-buffered bit-serial shifter built around a 1-bit dual-port distributed RAM (RAMnnX1D-style).
- Each cycle, one bit of `in` is written into the current write bank.
- In the same cycle, the same bit position is read from the current read bank and registered into `out`.
- Generalises the fixed 16-bit, two-bank, switch-selected shifter: arbitrary width, N banks, and a frame-aligned swap handshake.
- Intended for LED/IO board tests and as a reusable buffering stage.

Parameters:
IO_WIDTH, 16, bits per frame; 2 <= IO_WIDTH <= 2^ADDR_WIDTH.
ADDR_WIDTH, 5, bit-position counter width.
NUM_BANKS, 2, number of frame buffers; power of two, >= 2.
BANK_WIDTH, clog2(NUM_BANKS), localparam, not overridable.
INIT, all zeros, RAM initial content; NUM_BANKS*2^ADDR_WIDTH bits; bit index = {bank, addr}.

Ports:
clk  in  1  single clock; all state on rising edge.
rst  in  1  synchronous, active-high reset.
in  in  IO_WIDTH  parallel data to capture.
out  out  IO_WIDTH  registered parallel data from read bank.
swap_req  in  1  request bank rotation at next frame boundary; level or pulse.
auto_swap  in  1  when high, rotate at every frame boundary.
swap_ack  out  1  one-cycle pulse: rotation took effect.
addr  out  ADDR_WIDTH  current bit position.
wr_bank  out  BANK_WIDTH  bank being written.
rd_bank  out  BANK_WIDTH  bank being read.

Behaviour:
- **Reset** (rst high at edge):
  - addr=0, wr_bank=0, rd_bank=NUM_BANKS-1.
  - out=0, swap_ack=0, pending flag cleared.
  - RAM contents untouched (INIT applies at configuration only).
- **Counter:** addr increments every cycle, IO_WIDTH-1 -> 0 wrap. Values >= IO_WIDTH never occur.
- **Boundary cycle:** the cycle with addr==IO_WIDTH-1.
- **Write:** every non-reset cycle, RAM[wr_bank][addr] <= in[addr] (WE tied high, synchronous write).
- **Read:**
  - rd_data = RAM[rd_bank][addr], asynchronous (DPO).
  - out[addr] <= rd_data at the edge; all other out bits hold.
  - rd_bank != wr_bank always, so there is no read/write collision.
- **Pending flag:**
  - Set by swap_req=1 in any non-reset cycle.
  - Multiple requests within one frame collapse to a single rotation.
  - swap_req in the boundary cycle itself counts for that boundary.
- **Rotation** at the boundary edge, if (pending | swap_req | auto_swap):
  - rd_bank <= wr_bank (the bank just completed).
  - wr_bank <= wr_bank+1 mod NUM_BANKS.
  - pending cleared.
  - swap_ack=1 for exactly the following cycle (addr==0).
- **Late request:** swap_req in the cycle where rotation commits is consumed by that rotation; it does not re-arm.
- **Latency:** bit k written in frame F appears on out[k] one cycle after addr==k in the first frame after the rotation that makes F's bank the read bank.
- **Reset mid-frame:** pending request discarded, no swap_ack, partial frame stays in RAM but the bank pointers return to reset values.
- Outputs are registered except addr, wr_bank and rd_bank, which are direct register values.

Decomposition:
- Shared package ram_shifter_pkg:
  - clog2 function.
  - Localparam DEFAULT_IO_WIDTH=16.
  - Typedef-free helper constant for INIT width computation.
- Sub-module dpram_dist_1b:
  - Parameters DEPTH_LOG2 = ADDR_WIDTH+BANK_WIDTH, INIT.
  - Ports clk, we, wa, d, ra, dpo.
  - Sync write, async read; maps onto RAM32X1D/RAM64X1D/RAM128X1D.
- Top-level owns counter, bank pointers, swap FSM (IDLE/PENDING) and out register.
- Expected size about 180 lines.

Test Plan:
1. rst held 2 cycles, defaults -> out=16'h0000, addr=0, wr_bank=0, rd_bank=1, swap_ack=0; addr then counts 0..15, 0.
2. in=16'hA5C3 held; swap_req pulse at addr=5 -> swap_ack high at next addr==0, wr_bank=1, rd_bank=0; after 16 further cycles out==16'hA5C3.
3. No swap, in toggling 16'hFFFF/16'h0000 -> out stays 16'h0000 (INIT of bank 1) indefinitely.
4. swap_req pulses at addr=3 and addr=9 -> exactly one swap_ack. swap_req only in the boundary cycle (addr=15) -> rotation at that boundary.
5. NUM_BANKS=4, auto_swap=1 -> swap_ack every 16 cycles; wr_bank 0,1,2,3,0; rd_bank 3,0,1,2,3. in=frame index -> out shows previous frame's value.
6. IO_WIDTH=12, ADDR_WIDTH=4: addr wraps 11->0. Separately, rst asserted at addr=7 with a swap pending -> no swap_ack, banks return to 0/1, addr restarts at 0.
